dma_pcie_h2c_crdt_mux: RTL

- Parametrised multi-channel H2C transmit mux that drives the credit-based H2C stream toward the PCIe DMA core.
- Accepts NUM_CH independent AXI-Stream-style sources and keeps one beat-credit counter per channel.
- Arbitrates round-robin at packet boundaries and sends one beat only when the selected channel holds credit.
- Generalises the fixed 512-bit / 4-channel credit interface to arbitrary width, channel count and credit depth, and adds overflow detection.

---
 rtl/dma_pcie_h2c_crdt_pkg.sv | 28 ++
 rtl/dma_pcie_h2c_crdt_if.sv | 50 +++++
 rtl/dma_pcie_h2c_rr_arb.sv | 43 ++++
 rtl/dma_pcie_h2c_crdt_mux.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dma_pcie_h2c_crdt_pkg.sv
// ---------------------------------------------------------------------------
// dma_pcie_h2c_crdt_pkg
// Shared definitions for the credit-based H2C transmit mux:
//   ch_width()    - channel index width, $clog2(NUM_CH), never below 1
//   crdt_width()  - per-channel credit counter width, $clog2(MAX_CRDT+1)
//   state_e       - packet-lock FSM states (IDLE, LOCK)
//   byte_parity() - even parity of one byte (used when parity is enabled)
// ---------------------------------------------------------------------------
package dma_pcie_h2c_crdt_pkg;

  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int unsigned crdt_width(input int unsigned max_crdt);
    return $clog2(max_crdt + 1);
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dma_pcie_h2c_crdt_if.sv
// ---------------------------------------------------------------------------
// dma_pcie_h2c_crdt_if
// Bundles the NUM_CH source streams, the muxed H2C output stream and the
// credit-return sideband.
//   slave  : the mux view (sources and credits in, ready/output stream out)
//   master : the environment view (drives sources and credits)
// Source channel c occupies slice c of every s_* vector.
// ---------------------------------------------------------------------------
interface dma_pcie_h2c_crdt_if
  import dma_pcie_h2c_crdt_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned USR_W  = 64,
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned CH_W   = ch_width(NUM_CH);
  localparam int unsigned KEEP_W = DATA_W / 8;

  logic [NUM_CH*DATA_W-1:0] s_tdata;
  logic [NUM_CH*KEEP_W-1:0] s_tkeep;
  logic [NUM_CH*USR_W-1:0]  s_tusr;
  logic [NUM_CH-1:0]        s_tlast;
  logic [NUM_CH-1:0]        s_tvalid;
  logic [NUM_CH-1:0]        s_tready;

  logic [DATA_W-1:0]        m_tdata;
  logic [KEEP_W-1:0]        m_tparity;
  logic [KEEP_W-1:0]        m_tkeep;
  logic [USR_W-1:0]         m_tusr;
  logic                     m_tlast;
  logic                     m_tvalid;
  logic [CH_W-1:0]          m_tch;

  logic                     crdt;
  logic [CH_W-1:0]          crdt_ch;
  logic                     crdt_ovf_err;

  modport slave (
    input  s_tdata, s_tkeep, s_tusr, s_tlast, s_tvalid, crdt, crdt_ch,
    output s_tready, m_tdata, m_tparity, m_tkeep, m_tusr, m_tlast, m_tvalid,
           m_tch, crdt_ovf_err
  );

  modport master (
    output s_tdata, s_tkeep, s_tusr, s_tlast, s_tvalid, crdt, crdt_ch,
    input  s_tready, m_tdata, m_tparity, m_tkeep, m_tusr, m_tlast, m_tvalid,
           m_tch, crdt_ovf_err
  );

endinterface

// File: rtl/dma_pcie_h2c_rr_arb.sv
// ---------------------------------------------------------------------------
// dma_pcie_h2c_rr_arb
// Combinational round-robin arbiter: grants the first asserted request found
// searching upward from ptr_i, wrapping at NUM_CH.
//   req_i     - request vector
//   ptr_i     - highest-priority channel this cycle
//   gnt_oh_o  - one-hot grant
//   gnt_idx_o - index of the granted channel
//   gnt_vld_o - some request was granted
// ---------------------------------------------------------------------------
module dma_pcie_h2c_rr_arb #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] gnt_oh_o,
  output logic [CH_W-1:0]   gnt_idx_o,
  output logic              gnt_vld_o
);

  int unsigned idx;

  // NOTE: every output gets a default before the search so no path through
  // this block leaves a variable unassigned (which would infer a latch).
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    // Walk from the farthest candidate back to ptr_i so the last hit written
    // is the nearest one in round-robin order.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % NUM_CH;
      if (req_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = CH_W'(idx);
      end
    end
    gnt_oh_o[gnt_idx_o] = gnt_vld_o;
  end

endmodule

// File: rtl/dma_pcie_h2c_crdt_mux.sv
// ---------------------------------------------------------------------------
// dma_pcie_h2c_crdt_mux
// Multi-channel H2C transmit mux toward the PCIe DMA core. Each channel keeps
// a beat-credit counter; channels are arbitrated round-robin at packet
// boundaries and a beat is only accepted when its channel holds credit.
// A packet, once started, locks the output until its tlast beat.
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset
//   h2c  - dma_pcie_h2c_crdt_if.slave: NUM_CH source streams (s_*), the
//          registered output stream (m_*, no backpressure), credit return
//          (crdt, crdt_ch) and the sticky credit-overflow flag.
// Optional feature: define DMA_H2C_CRDT_PARITY_EN to generate registered
// even per-byte parity on m_tparity; otherwise m_tparity is tied to 0.
// ---------------------------------------------------------------------------
module dma_pcie_h2c_crdt_mux
  import dma_pcie_h2c_crdt_pkg::*;
#(
  parameter int unsigned DATA_W   = 512,
  parameter int unsigned USR_W    = 64,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned MAX_CRDT = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  dma_pcie_h2c_crdt_if.slave      h2c
);

  localparam int unsigned CH_W   = ch_width(NUM_CH);
  localparam int unsigned CRDT_W = crdt_width(MAX_CRDT);
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam logic [CRDT_W-1:0] CRDT_MAX = CRDT_W'(MAX_CRDT);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CRDT_W-1:0]   cnt_q [NUM_CH];
  logic                crdt_ovf_q;

  logic [NUM_CH-1:0]   elig, gnt_oh, rdy, crdt_inc, crdt_dec;
  logic [CH_W-1:0]     gnt_idx, sel;
  logic                gnt_vld, xfer;
  logic [DATA_W-1:0]   sel_data;

  logic [DATA_W-1:0]   m_tdata_q;
  logic [KEEP_W-1:0]   m_tkeep_q;
  logic [USR_W-1:0]    m_tusr_q;
  logic                m_tlast_q, m_tvalid_q;
  logic [CH_W-1:0]     m_tch_q;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c] = h2c.s_tvalid[c] && (cnt_q[c] != '0);
    end
  end

  dma_pcie_h2c_rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_arb (
    .req_i     (elig),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Packet-lock FSM; the IDLE grant is combinational so the first beat of a
  // packet transfers in the same cycle it wins arbitration.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    rdy       = '0;
    sel       = lock_ch_q;
    xfer      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          sel      = gnt_idx;
          rdy      = gnt_oh;
          xfer     = 1'b1;
          rr_ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + CH_W'(1);
          if (!h2c.s_tlast[gnt_idx]) begin
            state_d   = ST_LOCK;
            lock_ch_d = gnt_idx;
          end
        end
      end
      ST_LOCK: begin
        // Credit starvation simply withholds ready; the lock is kept.
        rdy[lock_ch_q] = (cnt_q[lock_ch_q] != '0);
        xfer           = rdy[lock_ch_q] && h2c.s_tvalid[lock_ch_q];
        if (xfer && h2c.s_tlast[lock_ch_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign h2c.s_tready = rdy;
  assign sel_data     = h2c.s_tdata[sel*DATA_W +: DATA_W];

  // An out-of-range crdt_ch matches no channel and is therefore dropped.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      crdt_inc[c] = h2c.crdt && (int'(h2c.crdt_ch) == c);
      crdt_dec[c] = xfer && (int'(sel) == c);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lock_ch_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Simultaneous return and consumption on one channel cancel out, so that
  // case never reaches the saturation check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the counter array is reset explicitly; credits granted before
      // reset are void and the sink must re-grant them.
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
      crdt_ovf_q <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (crdt_inc[c] && !crdt_dec[c]) begin
          if (cnt_q[c] == CRDT_MAX) crdt_ovf_q <= 1'b1;
          else                      cnt_q[c]   <= cnt_q[c] + 1'b1;
        end else if (crdt_dec[c] && !crdt_inc[c]) begin
          cnt_q[c] <= cnt_q[c] - 1'b1;
        end
      end
    end
  end

  // Output register: payload fields hold their last value between beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tusr_q   <= '0;
      m_tlast_q  <= 1'b0;
      m_tch_q    <= '0;
    end else begin
      m_tvalid_q <= xfer;
      if (xfer) begin
        m_tdata_q <= sel_data;
        m_tkeep_q <= h2c.s_tkeep[sel*KEEP_W +: KEEP_W];
        m_tusr_q  <= h2c.s_tusr[sel*USR_W +: USR_W];
        m_tlast_q <= h2c.s_tlast[sel];
        m_tch_q   <= sel;
      end
    end
  end

`ifdef DMA_H2C_CRDT_PARITY_EN
  logic [KEEP_W-1:0] par_d, m_tparity_q;

  always_comb begin
    for (int i = 0; i < KEEP_W; i++) par_d[i] = byte_parity(sel_data[8*i +: 8]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       m_tparity_q <= '0;
    else if (xfer) m_tparity_q <= par_d;
  end

  assign h2c.m_tparity = m_tparity_q;
`else
  assign h2c.m_tparity = '0;
`endif

  assign h2c.m_tdata      = m_tdata_q;
  assign h2c.m_tkeep      = m_tkeep_q;
  assign h2c.m_tusr       = m_tusr_q;
  assign h2c.m_tlast      = m_tlast_q;
  assign h2c.m_tvalid     = m_tvalid_q;
  assign h2c.m_tch        = m_tch_q;
  assign h2c.crdt_ovf_err = crdt_ovf_q;

endmodule
